// File: rtl/home_sec_pkg.sv
// -----------------------------------------------------------------------------
// home_sec_pkg
// Shared types for the home security block: the alarm sequencer state codes
// and the zone codes latched into the sequencer's cause register.
// No ports (package).
// -----------------------------------------------------------------------------
package home_sec_pkg;

    // Sequencer state codes; 3'd6 and 3'd7 are unused and recover to DISARMED.
    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_EXIT_DLY  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ENTRY_DLY = 3'd3,
        ST_ALARM     = 3'd4,
        ST_FIRE      = 3'd5
    } state_e;

    // Zone that caused the current alarm condition.
    typedef enum logic [2:0] {
        ZONE_NONE   = 3'd0,
        ZONE_DOOR   = 3'd1,
        ZONE_WINDOW = 3'd2,
        ZONE_GARAGE = 3'd3,
        ZONE_FIRE   = 3'd4
    } zone_e;

endpackage

// File: rtl/sec_delay_timer.sv
// -----------------------------------------------------------------------------
// sec_delay_timer
// Down-counter used by the alarm sequencer for exit delay, entry delay and
// siren duration. Loading value V gives exactly V+1 cycles until done is seen
// at the following state decision, so the caller loads CYCLES-1.
// Ports:
//   clock  in         system clock, rising edge
//   reset  in         asynchronous, active-high; count returns to 0
//   load   in         load 'value' into the counter this cycle
//   value  in  CNT_W  count to load
//   done   out        count is zero
// -----------------------------------------------------------------------------
module sec_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
// Arm/disarm controller for the home security block: exit delay, armed watch,
// entry delay, timed intrusion siren and latched fire alarm. All outputs are
// registered and reflect the inputs sampled at the previous rising edge.
// Optional feature macro: ALARM_SEQ_CHIME_EN (door chime in DISARMED).
// Ports:
//   clock       in      system clock, rising edge
//   reset       in      asynchronous, active-high
//   arm_req     in      1-cycle pulse: request arming
//   disarm_req  in      1-cycle pulse: valid user code entered
//   door        in      raw door sensor level
//   window      in      raw window sensor level
//   garage      in      raw garage sensor level
//   fire        in      raw fire sensor level
//   flag        out     1 = intrusion alarms masked in the sensor modules
//   armed       out     1 in ARMED, ENTRY_DLY, ALARM
//   siren       out     1 in ALARM and FIRE
//   state       out 3   current state code
//   cause       out 3   latched zone code
//   chime       out     door chime pulse (0 unless ALARM_SEQ_CHIME_EN)
// -----------------------------------------------------------------------------
module alarm_sequencer #(
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 8,
    parameter int SIREN_CYCLES = 32,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm_req,
    input  logic       disarm_req,
    input  logic       door,
    input  logic       window,
    input  logic       garage,
    input  logic       fire,
    output logic       flag,
    output logic       armed,
    output logic       siren,
    output logic [2:0] state,
    output logic [2:0] cause,
    output logic       chime
);

    import home_sec_pkg::*;

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    state_e           state_q, state_d;
    zone_e            cause_q, cause_d;
    logic             flag_q, flag_d;
    logic             armed_q, armed_d;
    logic             siren_q, siren_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_done;

    sec_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    // Next-state logic. Fire overrides everything; otherwise disarm_req wins
    // over arm_req and over any intrusion zone seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        timer_load  = 1'b0;
        timer_value = '0;

        if (fire) begin
            state_d = ST_FIRE;
            cause_d = ZONE_FIRE;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (arm_req && !disarm_req) begin
                        state_d     = ST_EXIT_DLY;
                        timer_load  = 1'b1;
                        timer_value = EXIT_LOAD;
                    end
                end
                ST_EXIT_DLY: begin
                    if (disarm_req)      state_d = ST_DISARMED;
                    else if (timer_done) state_d = ST_ARMED;
                end
                ST_ARMED, ST_ENTRY_DLY: begin
                    // Window beats garage beats door; door only opens the
                    // entry delay from ARMED.
                    if (disarm_req) begin
                        state_d = ST_DISARMED;
                    end else if (window) begin
                        state_d     = ST_ALARM;
                        cause_d     = ZONE_WINDOW;
                        timer_load  = 1'b1;
                        timer_value = SIREN_LOAD;
                    end else if (garage) begin
                        state_d     = ST_ALARM;
                        cause_d     = ZONE_GARAGE;
                        timer_load  = 1'b1;
                        timer_value = SIREN_LOAD;
                    end else if (state_q == ST_ARMED) begin
                        if (door) begin
                            state_d     = ST_ENTRY_DLY;
                            cause_d     = ZONE_DOOR;
                            timer_load  = 1'b1;
                            timer_value = ENTRY_LOAD;
                        end
                    end else if (timer_done) begin
                        // Entry delay expired without a disarm; cause stays door.
                        state_d     = ST_ALARM;
                        timer_load  = 1'b1;
                        timer_value = SIREN_LOAD;
                    end
                end
                ST_ALARM: begin
                    if (disarm_req)      state_d = ST_DISARMED;
                    else if (timer_done) state_d = ST_ARMED;
                end
                ST_FIRE: begin
                    // Only reached with fire low, so disarm may release it.
                    if (disarm_req) state_d = ST_DISARMED;
                end
                default: state_d = ST_DISARMED;
            endcase
        end

        if (state_d == ST_DISARMED) begin
            cause_d = ZONE_NONE;
        end

        // Outputs decoded from the next state so they register alongside it.
        flag_d  = (state_d == ST_DISARMED) || (state_d == ST_EXIT_DLY);
        armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DLY) ||
                  (state_d == ST_ALARM);
        siren_d = (state_d == ST_ALARM) || (state_d == ST_FIRE);
    end

    // NOTE: asynchronous reset clears the FSM and outputs immediately, so a
    // reset mid-siren silences it without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_DISARMED;
            cause_q <= ZONE_NONE;
            flag_q  <= 1'b1;
            armed_q <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            flag_q  <= flag_d;
            armed_q <= armed_d;
            siren_q <= siren_d;
        end
    end

    assign state = state_q;
    assign cause = cause_q;
    assign flag  = flag_q;
    assign armed = armed_q;
    assign siren = siren_q;

`ifdef ALARM_SEQ_CHIME_EN
    // Door rising-edge detector; chime only while disarmed.
    logic door_q;
    logic chime_q, chime_d;

    always_comb begin
        chime_d = (state_q == ST_DISARMED) && door && !door_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            door_q  <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            door_q  <= door;
            chime_q <= chime_d;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
// Self-checking bench for alarm_sequencer with default parameters. A reference
// model tracks the current mode and how many cycles have been spent in it;
// directed scenarios and a randomized run are compared against it and against
// fixed expected values.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

    localparam int EXIT_CYCLES  = 16;
    localparam int ENTRY_CYCLES = 8;
    localparam int SIREN_CYCLES = 32;

    localparam int M_DISARMED = 0;
    localparam int M_EXIT     = 1;
    localparam int M_ARMED    = 2;
    localparam int M_ENTRY    = 3;
    localparam int M_ALARM    = 4;
    localparam int M_FIRE     = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       arm_req, disarm_req, door, window, garage, fire;
    logic       flag, armed, siren, chime;
    logic [2:0] state, cause;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    alarm_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .arm_req    (arm_req),
        .disarm_req (disarm_req),
        .door       (door),
        .window     (window),
        .garage     (garage),
        .fire       (fire),
        .flag       (flag),
        .armed      (armed),
        .siren      (siren),
        .state      (state),
        .cause      (cause),
        .chime      (chime)
    );

    wire [9:0] dut_vec = {state, flag, armed, siren, cause, chime};

    // ---------------- reference model ----------------
    int   m_mode;   // current mode
    int   m_cause;  // latched zone
    int   m_age;    // cycles spent in current mode, 1 in the first cycle
    logic m_chime;
`ifdef ALARM_SEQ_CHIME_EN
    logic m_door_prev;
`endif

    task automatic model_reset();
        m_mode  = M_DISARMED;
        m_cause = 0;
        m_age   = 1;
        m_chime = 1'b0;
`ifdef ALARM_SEQ_CHIME_EN
        m_door_prev = 1'b0;
`endif
    endtask

    task automatic model_step();
        int nxt;
        int ncause;
        nxt    = m_mode;
        ncause = m_cause;
        m_chime = 1'b0;
`ifdef ALARM_SEQ_CHIME_EN
        m_chime     = (m_mode == M_DISARMED) && door && !m_door_prev;
        m_door_prev = door;
`endif
        if (fire) begin
            nxt = M_FIRE; ncause = 4;
        end else if (m_mode == M_DISARMED) begin
            if (arm_req && !disarm_req) nxt = M_EXIT;
        end else if (disarm_req) begin
            nxt = M_DISARMED;
        end else if (m_mode == M_EXIT) begin
            if (m_age == EXIT_CYCLES) nxt = M_ARMED;
        end else if (m_mode == M_ARMED || m_mode == M_ENTRY) begin
            if (window)                                     begin nxt = M_ALARM; ncause = 2; end
            else if (garage)                                begin nxt = M_ALARM; ncause = 3; end
            else if (m_mode == M_ARMED && door)             begin nxt = M_ENTRY; ncause = 1; end
            else if (m_mode == M_ENTRY && m_age == ENTRY_CYCLES) nxt = M_ALARM;
        end else if (m_mode == M_ALARM) begin
            if (m_age == SIREN_CYCLES) nxt = M_ARMED;
        end
        if (nxt == M_DISARMED) ncause = 0;
        m_age   = (nxt == m_mode) ? m_age + 1 : 1;
        m_mode  = nxt;
        m_cause = ncause;
    endtask

    function automatic logic [9:0] model_vec();
        logic f, a, s;
        f = (m_mode == M_DISARMED) || (m_mode == M_EXIT);
        a = (m_mode == M_ARMED) || (m_mode == M_ENTRY) || (m_mode == M_ALARM);
        s = (m_mode == M_ALARM) || (m_mode == M_FIRE);
        return {3'(m_mode), f, a, s, 3'(m_cause), m_chime};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic a, input logic d, input logic dr,
                         input logic w, input logic g, input logic f);
        arm_req = a; disarm_req = d; door = dr; window = w; garage = g; fire = f;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_armed();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (EXIT_CYCLES) idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        arm_req = 0; disarm_req = 0; door = 0; window = 0; garage = 0; fire = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
        end
        @(negedge clock);
        reset = 1'b0;
        idle();
        vectors++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_arm_exit();
        for (int i = 0; i < EXIT_CYCLES; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else        idle();
            vectors++;
            if (state !== 3'd1 || flag !== 1'b1 || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL exit_delay cycle %0d: got %b expected %b", i, dut_vec, model_vec());
            end
        end
        idle();
        vectors++;
        if (state !== 3'd2 || armed !== 1'b1 || flag !== 1'b0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL armed_after_exit: got %b expected state=2 armed=1 flag=0", dut_vec);
        end
    endtask

    task automatic test_entry_disarm();
        logic siren_seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        siren_seen = siren;
        vectors++;
        if (state !== 3'd3 || cause !== 3'd1) begin
            errors++;
            $display("FAIL entry_start: got state=%0d cause=%0d expected 3/1", state, cause);
        end
        repeat (3) begin
            idle();
            siren_seen = siren_seen | siren;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        siren_seen = siren_seen | siren;
        vectors++;
        if (state !== 3'd0 || cause !== 3'd0 || siren_seen !== 1'b0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL entry_disarm: got %b siren_seen=%b expected state=0 cause=0 siren_seen=0",
                     dut_vec, siren_seen);
        end
    endtask

    task automatic test_entry_expire();
        int n;
        go_armed();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && state == 3'd3; i++) begin
            n++;
            idle();
        end
        vectors++;
        if (n != ENTRY_CYCLES || state !== 3'd4 || cause !== 3'd1 || siren !== 1'b1) begin
            errors++;
            $display("FAIL entry_expiry: got %0d entry cycles state=%0d cause=%0d expected %0d/4/1",
                     n, state, cause, ENTRY_CYCLES);
        end
        n = 0;
        for (int i = 0; i < 80 && siren == 1'b1; i++) begin
            n++;
            idle();
        end
        vectors++;
        if (n != SIREN_CYCLES || state !== 3'd2 || cause !== 3'd1 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL siren_duration: got %0d siren cycles state=%0d cause=%0d expected %0d/2/1",
                     n, state, cause, SIREN_CYCLES);
        end
    endtask

    task automatic test_zone_priority();
        // Still armed from the previous scenario.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (state !== 3'd4 || cause !== 3'd2 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL window_priority: got state=%0d cause=%0d expected 4/2", state, cause);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (state !== 3'd5 || cause !== 3'd4 || siren !== 1'b1) begin
            errors++;
            $display("FAIL fire_entry: got state=%0d cause=%0d siren=%b expected 5/4/1", state, cause, siren);
        end
    endtask

    task automatic test_fire_exit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (state !== 3'd5 || siren !== 1'b1) begin
            errors++;
            $display("FAIL fire_disarm_ignored: got state=%0d siren=%b expected 5/1", state, siren);
        end
        idle();
        vectors++;
        if (state !== 3'd5 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL fire_latched: got state=%0d expected 5", state);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (state !== 3'd0 || siren !== 1'b0 || flag !== 1'b1 || cause !== 3'd0) begin
            errors++;
            $display("FAIL fire_release: got %b expected state=0 siren=0 flag=1 cause=0", dut_vec);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (state !== 3'd0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL arm_disarm_same_cycle: got state=%0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid_alarm();
        go_armed();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) idle();
        vectors++;
        if (state !== 3'd4 || cause !== 3'd3 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL garage_alarm: got state=%0d cause=%0d expected 4/3", state, cause);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (state !== 3'd0 || siren !== 1'b0 || flag !== 1'b1 || cause !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected state=0 siren=0 flag=1 cause=0", dut_vec);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                  $urandom_range(31) == 0, $urandom_range(31) == 0, $urandom_range(63) == 0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm_exit();
        test_entry_disarm();
        test_entry_expire();
        test_zone_priority();
        test_fire_exit();
        test_reset_mid_alarm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
